// File: rtl/spmem_pkg.sv
// spmem_pkg: shared state type, latency limit and parameter sanity check for the spmem responder
package spmem_pkg;

    typedef enum logic {
        INIT,
        READY
    } spmem_state_e;

    localparam int SPMEM_MAX_RD_LATENCY = 4;

    function automatic bit spmem_params_ok(input int rd_latency, input int depth);
        return rd_latency >= 1 && rd_latency <= SPMEM_MAX_RD_LATENCY && depth >= 2;
    endfunction

endpackage

// File: rtl/spmem_if.sv
// spmem_if: device-side spmem bus bundle with master and slave views
interface spmem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);

    logic                  spmem_cs_n;
    logic                  spmem_wr_n;
    logic [ADDR_WIDTH-1:0] spmem_addr;
    logic [DATA_WIDTH-1:0] spmem_be;
    logic [DATA_WIDTH-1:0] spmem_d;
    logic [DATA_WIDTH-1:0] spmem_q;
    logic                  spmem_q_valid;
    logic                  spmem_err;
    logic                  spmem_init_busy;

    modport master (
        output spmem_cs_n, spmem_wr_n, spmem_addr, spmem_be, spmem_d,
        input  spmem_q, spmem_q_valid, spmem_err, spmem_init_busy
    );

    modport slave (
        input  spmem_cs_n, spmem_wr_n, spmem_addr, spmem_be, spmem_d,
        output spmem_q, spmem_q_valid, spmem_err, spmem_init_busy
    );

endinterface

// File: rtl/spmem_rd_pipe.sv
// spmem_rd_pipe: fixed-latency read response pipeline; the last stage holds spmem_q between responses
module spmem_rd_pipe
    import spmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  spmem_clk,
    input  logic                  spmem_rst,
    input  logic                  in_valid,
    input  logic                  in_err,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  q_valid,
    output logic                  q_err,
    output logic [DATA_WIDTH-1:0] q
);

    logic [RD_LATENCY-1:0] vld;
    logic [RD_LATENCY-1:0] err;
    logic [DATA_WIDTH-1:0] dat [RD_LATENCY];

    // valid/err shift every cycle; data only advances behind a valid so the final stage keeps the last response
    always_ff @(posedge spmem_clk) begin
        if (spmem_rst) begin
            vld <= '0;
            err <= '0;
            for (int i = 0; i < RD_LATENCY; i++) dat[i] <= '0;
        end else begin
            vld <= RD_LATENCY'({vld, in_valid});
            err <= RD_LATENCY'({err, in_err & in_valid});
            if (in_valid) dat[0] <= in_data;
            for (int i = 1; i < RD_LATENCY; i++) if (vld[i-1]) dat[i] <= dat[i-1];
        end
    end

    assign q_valid = vld[RD_LATENCY-1];
    assign q_err   = err[RD_LATENCY-1];
    assign q       = dat[RD_LATENCY-1];

endmodule

// File: rtl/spmem_responder.sv
// spmem_responder: zero-filled scratchpad with masked writes and fixed-latency reads on the spmem bus
module spmem_responder
    import spmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 1
) (
    input logic    spmem_clk,
    input logic    spmem_rst,
    spmem_if.slave bus
);

    localparam int IW = $clog2(DEPTH);

    if (!spmem_params_ok(RD_LATENCY, DEPTH)) begin : g_bad_params
        $error("spmem_responder: RD_LATENCY must be 1..%0d and DEPTH must be >= 2", SPMEM_MAX_RD_LATENCY);
    end

    spmem_state_e          state;
    spmem_state_e          state_nxt;
    logic [IW-1:0]         fill_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]         idx;
    logic                  req;
    logic                  in_range;
    logic                  fill_last;
    logic                  init_busy;
    logic                  wr_ok;
    logic                  rd_req;
    logic                  drop_nxt;
    logic                  drop_err;
    logic                  pipe_err;
    logic                  mem_we;
    logic [IW-1:0]         mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] rd_data;

    assign req       = !bus.spmem_cs_n;
    assign in_range  = bus.spmem_addr < ADDR_WIDTH'(DEPTH);
    assign idx       = bus.spmem_addr[IW-1:0];
    assign fill_last = fill_cnt == IW'(DEPTH - 1);

    // state register and zero-fill counter; reset restarts the fill from address 0
    always_ff @(posedge spmem_clk) begin
        if (spmem_rst) begin
            state    <= INIT;
            fill_cnt <= '0;
        end else begin
            state    <= state_nxt;
            fill_cnt <= state == INIT ? fill_cnt + IW'(1) : fill_cnt;
        end
    end

    // leave INIT on the edge that writes the last word
    always_comb begin
        state_nxt = (state == INIT && fill_last) ? READY : state;
    end

    // request decode; anything seen during INIT is dropped, out-of-range writes are dropped too
    always_comb begin
        init_busy = state == INIT;
        wr_ok     = !init_busy && req && !bus.spmem_wr_n && in_range;
        rd_req    = !init_busy && req && bus.spmem_wr_n;
        drop_nxt  = req && (init_busy || (!bus.spmem_wr_n && !in_range));
        mem_we    = init_busy || wr_ok;
        mem_wa    = init_busy ? fill_cnt : idx;
        mem_wd    = init_busy ? '0 : (mem[idx] & ~bus.spmem_be) | (bus.spmem_d & bus.spmem_be);
        rd_data   = in_range ? mem[idx] : '0;
    end

    // single write port shared by the zero-fill and masked bus writes
    always_ff @(posedge spmem_clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    // one-cycle error pulse for requests that produce no read response
    always_ff @(posedge spmem_clk) begin
        if (spmem_rst) drop_err <= 1'b0;
        else drop_err <= drop_nxt;
    end

    spmem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .spmem_clk (spmem_clk),
        .spmem_rst (spmem_rst),
        .in_valid  (rd_req),
        .in_err    (!in_range),
        .in_data   (rd_data),
        .q_valid   (bus.spmem_q_valid),
        .q_err     (pipe_err),
        .q         (bus.spmem_q)
    );

    assign bus.spmem_init_busy = init_busy;
    assign bus.spmem_err       = drop_err | pipe_err;

endmodule

// File: doc/spmem_responder.md
# spmem_responder

Synthesizable scratchpad-memory responder that sits on the device side of the spmem bus. It accepts chip-select/write-enable/address/bit-mask/data requests and applies masked writes to an internal array. It returns read data on spmem_q after a fixed, parameterized latency. After every reset it zero-fills the array, then serves one request per cycle at full throughput.

## Interface
- DATA_WIDTH, 32, width of spmem_d, spmem_be, spmem_q
- ADDR_WIDTH, 32, width of spmem_addr
- DEPTH, 1024, number of words stored (legal addresses 0..DEPTH-1)
- RD_LATENCY, 1, read latency in cycles, legal 1..4

Ports:
- spmem_clk  in  1  clock; all logic on posedge
- spmem_rst  in  1  reset, synchronous, active-high
- spmem_cs_n  in  1  chip select, active-low
- spmem_wr_n  in  1  0 = write, 1 = read (qualified by spmem_cs_n=0)
- spmem_addr  in  ADDR_WIDTH  word address
- spmem_be  in  DATA_WIDTH  per-bit write mask; bit i enables spmem_d[i]
- spmem_d  in  DATA_WIDTH  write data
- spmem_q  out  DATA_WIDTH  read data, held until the next read response
- spmem_q_valid  out  1  one-cycle pulse per read response
- spmem_err  out  1  one-cycle pulse: out-of-range or dropped request
- spmem_init_busy  out  1  high while the post-reset zero-fill runs

## Operation
- FSM states: INIT, READY. Reset forces INIT with the fill counter at 0.
- INIT: writes '0 to mem[fill_cnt] each cycle and increments fill_cnt. When fill_cnt=DEPTH-1 is written, the FSM moves to READY at that edge. INIT lasts exactly DEPTH cycles.
- Any request (cs_n=0) sampled in INIT is dropped: no write, no read response, and spmem_err pulses at the next edge.
- READY write (cs_n=0, wr_n=0, addr<DEPTH): mem[addr] <= (mem[addr] & ~be) | (d & be). be='0 is a legal no-op write.
- READY read (cs_n=0, wr_n=1, addr<DEPTH): mem[addr] enters the read pipeline.
- Out of range (addr>=DEPTH), write: dropped; spmem_err pulses at edge N+1.
- Out of range (addr>=DEPTH), read: returns '0 with spmem_q_valid, and spmem_err pulses coincident with spmem_q_valid.
- Only the full address is compared; high address bits are never truncated or aliased.
- cs_n=1: idle. spmem_wr_n, spmem_addr, spmem_be and spmem_d are ignored.

## Timing
- Reset values: spmem_q='0, spmem_q_valid=0, spmem_err=0, spmem_init_busy=1. The read pipeline is flushed. Array contents are undefined until INIT completes.
- Reset asserted mid-operation: in-flight reads are discarded with no valid pulse, and INIT restarts from address 0.
- spmem_init_busy falls at the same edge the FSM enters READY. A request sampled at that edge is still dropped; the first accepted request is sampled one edge later.
- Read latency: a request sampled at edge N gives spmem_q/spmem_q_valid updated at edge N+RD_LATENCY.
- Back-to-back reads give one response per cycle, in order.
- Write takes effect at the sampling edge. A read of the same address sampled at N+1 returns the new data, for any RD_LATENCY.
- A write in the cycle after a read does not alter that read's in-flight data.
- spmem_q holds its last value when no response is due. It never returns to '0 on its own.

## Structure
- spmem_pkg holds:
  - state enum spmem_state_e {INIT, READY}
  - constant SPMEM_MAX_RD_LATENCY=4
  - a static parameter check requiring 1<=RD_LATENCY<=SPMEM_MAX_RD_LATENCY and DEPTH>=2
- Sub-module spmem_rd_pipe: RD_LATENCY-stage shift register of {valid, err, data}, with synchronous flush on spmem_rst. It drives spmem_q, spmem_q_valid and the read-path err.
- Top level holds the array, FSM, fill counter, masked-write logic and write-path err register. The two err sources are ORed.

## Test plan
- Reset, then idle: spmem_init_busy high for exactly DEPTH cycles. Reading addresses 0, 5 and DEPTH-1 then returns 0, each with q_valid at N+RD_LATENCY.
- Write addr 3, d=32'hDEAD_BEEF, be='1. Then write addr 3, d=32'h0000_0000, be=32'h0000_FFFF. Then read addr 3 -> spmem_q=32'hDEAD_0000.
- Write addr 7 =32'h1234_5678 at edge N, read addr 7 at N+1, for RD_LATENCY=1 and 4 -> 32'h1234_5678 at N+1+RD_LATENCY.
- Read addr DEPTH -> q='0, q_valid=1 and err=1 together. Write addr DEPTH -> err at N+1, and a later read of addr 0 is unchanged.
- 16 back-to-back reads of addrs 0..15 (preloaded 0x100+i) -> 16 consecutive q_valid pulses with data in order.
- Issue 3 reads, then assert spmem_rst one cycle later -> no q_valid pulses. spmem_q=0, and init_busy high again for DEPTH cycles.
- A request during INIT -> err at the next edge, no q_valid, and the array is still all zero after INIT.
